// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
//
// Sequencing controller for the digital lock. Collects decoded keypad events
// into a 4-digit BCD entry buffer, checks the buffer against the stored code,
// counts consecutive failed checks into a timed lockout, and lets an unlocked
// user reprogram the code. Drives four digit glyphs and one status glyph for
// the 7-segment scanner.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous assert, active-low reset
//   key_valid  one-cycle key strobe
//   key_code   0-9 digit, A clear, B enter, C program, D-F ignored
//   seg0       rightmost digit glyph (most recent digit)
//   seg1..seg3 successively older digit glyphs
//   segStatus  status glyph: L locked/check, U unlocked, P program, E lockout
//   unlocked   high in UNLOCKED and PROGRAM
//   alarm      high in LOCKOUT
//
// All glyphs are registered, active-low, ordered {g,f,e,d,c,b,a};
// 7'b1111111 is blank.
// -----------------------------------------------------------------------------
module lock_controller #(
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter logic [15:0] RESET_CODE     = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] segStatus,
  output logic       unlocked,
  output logic       alarm
);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  localparam logic [6:0]  BLANK     = 7'b1111111;
  localparam logic [6:0]  GLYPH_L   = 7'b1000111;
  localparam logic [6:0]  GLYPH_U   = 7'b1000001;
  localparam logic [6:0]  GLYPH_P   = 7'b0001100;
  localparam logic [6:0]  GLYPH_E   = 7'b0000110;
  localparam logic [2:0]  MAX_FAIL  = 3'(MAX_TRIES);
  localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES - 1);

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'b1000000;
      4'd1:    digit_glyph = 7'b1111001;
      4'd2:    digit_glyph = 7'b0100100;
      4'd3:    digit_glyph = 7'b0110000;
      4'd4:    digit_glyph = 7'b0011001;
      4'd5:    digit_glyph = 7'b0010010;
      4'd6:    digit_glyph = 7'b0000010;
      4'd7:    digit_glyph = 7'b1111000;
      4'd8:    digit_glyph = 7'b0000000;
      4'd9:    digit_glyph = 7'b0010000;
      default: digit_glyph = BLANK;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;     // nibble 0 = most recent digit
  logic [2:0]  count_q, count_d;     // valid digits in entry, 0..4
  logic [2:0]  fail_q, fail_d;       // consecutive failed checks
  logic [15:0] code_q, code_d;       // nibble 3 = first digit of the code
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic [27:0] seg_d;                // {seg3, seg2, seg1, seg0}
  logic [6:0]  status_d;

  logic key_digit, key_clear, key_enter, key_prog;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clear = key_valid && (key_code == 4'hA);
  assign key_enter = key_valid && (key_code == 4'hB);
  assign key_prog  = key_valid && (key_code == 4'hC);

  // Next-state logic for the sequencer and all datapath registers.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    fail_d     = fail_q;
    code_d     = code_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      // LOCKED and PROGRAM share buffer editing; they differ only in what
      // enter and program keys do.
      S_LOCKED, S_PROGRAM: begin
        if (key_digit) begin
          if (count_q != 3'd4) begin
            entry_d = {entry_q[11:0], key_code};
            count_d = count_q + 3'd1;
          end
        end else if (key_clear) begin
          count_d = 3'd0;
        end else if (key_enter && count_q == 3'd4) begin
          if (state_q == S_LOCKED) begin
            state_d = S_CHECK;
          end else begin
            code_d  = entry_q;
            count_d = 3'd0;
            state_d = S_UNLOCKED;
          end
        end else if (key_prog && state_q == S_PROGRAM) begin
          count_d = 3'd0;
          state_d = S_UNLOCKED;
        end
      end

      // One-cycle compare of registered buffer against registered code.
      S_CHECK: begin
        count_d = 3'd0;
        if (entry_q == code_q) begin
          fail_d  = 3'd0;
          state_d = S_UNLOCKED;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_d == MAX_FAIL) begin
            lock_cnt_d = LOCK_LOAD;
            state_d    = S_LOCKOUT;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end

      S_UNLOCKED: begin
        if (key_prog) begin
          count_d = 3'd0;
          state_d = S_PROGRAM;
        end else if (key_enter) begin
          count_d = 3'd0;
          state_d = S_LOCKED;
        end
      end

      // Counter was loaded with LOCKOUT_CYCLES-1 on entry, so the state is
      // held for exactly LOCKOUT_CYCLES cycles before leaving at zero.
      S_LOCKOUT: begin
        if (lock_cnt_q == 32'd0) begin
          fail_d  = 3'd0;
          state_d = S_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q - 32'd1;
        end
      end

      default: state_d = S_LOCKED;
    endcase
  end

  // Output decode from next-state values so the registered glyphs change on
  // the same edge as the state and buffer they depict.
  always_comb begin
    seg_d    = {4{BLANK}};
    status_d = GLYPH_L;
    if (state_d == S_LOCKED || state_d == S_UNLOCKED || state_d == S_PROGRAM) begin
      for (int i = 0; i < 4; i++) begin
        if (count_d > 3'(i)) seg_d[7*i +: 7] = digit_glyph(entry_d[4*i +: 4]);
      end
    end
    case (state_d)
      S_UNLOCKED: status_d = GLYPH_U;
      S_PROGRAM:  status_d = GLYPH_P;
      S_LOCKOUT:  status_d = GLYPH_E;
      default:    status_d = GLYPH_L;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation races between registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOCKED;
      entry_q    <= 16'h0000;
      count_q    <= 3'd0;
      fail_q     <= 3'd0;
      code_q     <= RESET_CODE;
      lock_cnt_q <= 32'd0;
      seg0       <= BLANK;
      seg1       <= BLANK;
      seg2       <= BLANK;
      seg3       <= BLANK;
      segStatus  <= GLYPH_L;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      lock_cnt_q <= lock_cnt_d;
      seg0       <= seg_d[6:0];
      seg1       <= seg_d[13:7];
      seg2       <= seg_d[20:14];
      seg3       <= seg_d[27:21];
      segStatus  <= status_d;
      unlocked   <= (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
      alarm      <= (state_d == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// -----------------------------------------------------------------------------
// tb_lock_controller
//
// Self-checking bench for lock_controller. A behavioural model keeps the entry
// as a queue of digits, the code as an array of digits and the lockout as a
// count of remaining visible cycles; after every clock edge all outputs are
// compared against what the model says should be on display.
// -----------------------------------------------------------------------------
module tb_lock_controller;

  localparam int unsigned LC = 16;
  localparam int unsigned MT = 3;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ST_L  = 7'b1000111;
  localparam logic [6:0] ST_U  = 7'b1000001;
  localparam logic [6:0] ST_P  = 7'b0001100;
  localparam logic [6:0] ST_E  = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [6:0] seg0, seg1, seg2, seg3, segStatus;
  logic       unlocked, alarm;

  lock_controller #(
    .LOCKOUT_CYCLES(LC),
    .MAX_TRIES     (MT),
    .RESET_CODE    (16'h1234)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3),
    .segStatus(segStatus),
    .unlocked (unlocked),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [6:0] glyph_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // ---------------- reference model ----------------
  typedef enum {M_LOCKED, M_CHECK, M_OPEN, M_PROGRAM, M_LOCKOUT} mode_e;

  mode_e mode;
  int    ent[$];     // digits in typing order, oldest first
  int    code_m[4];  // code digits in typing order
  int    fail_m;
  int    left_m;     // lockout cycles still to be shown

  task automatic model_reset();
    mode = M_LOCKED;
    ent.delete();
    code_m = '{1, 2, 3, 4};
    fail_m = 0;
    left_m = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] k);
    int kk;
    bit ok;
    kk = int'(k);
    case (mode)
      M_LOCKED, M_PROGRAM: begin
        if (v) begin
          if (kk <= 9) begin
            if (ent.size() < 4) ent.push_back(kk);
          end else if (kk == 10) begin
            ent.delete();
          end else if (kk == 11) begin
            if (ent.size() == 4) begin
              if (mode == M_LOCKED) mode = M_CHECK;
              else begin
                for (int j = 0; j < 4; j++) code_m[j] = ent[j];
                ent.delete();
                mode = M_OPEN;
              end
            end
          end else if (kk == 12 && mode == M_PROGRAM) begin
            ent.delete();
            mode = M_OPEN;
          end
        end
      end
      M_CHECK: begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++) if (ent[j] != code_m[j]) ok = 1'b0;
        ent.delete();
        if (ok) begin
          fail_m = 0;
          mode = M_OPEN;
        end else begin
          fail_m++;
          if (fail_m == int'(MT)) begin
            mode = M_LOCKOUT;
            left_m = int'(LC);
          end else begin
            mode = M_LOCKED;
          end
        end
      end
      M_OPEN: begin
        if (v && kk == 12) begin
          ent.delete();
          mode = M_PROGRAM;
        end else if (v && kk == 11) begin
          ent.delete();
          mode = M_LOCKED;
        end
      end
      M_LOCKOUT: begin
        left_m--;
        if (left_m == 0) begin
          fail_m = 0;
          mode = M_LOCKED;
        end
      end
      default: mode = M_LOCKED;
    endcase
  endtask

  function automatic logic [27:0] exp_segs();
    logic [27:0] r;
    int n;
    r = {4{BLANK}};
    n = ent.size();
    if (mode != M_CHECK && mode != M_LOCKOUT) begin
      for (int i = 0; i < n; i++) r[7*i +: 7] = glyph_tab[ent[n-1-i]];
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_status();
    case (mode)
      M_OPEN:    return ST_U;
      M_PROGRAM: return ST_P;
      M_LOCKOUT: return ST_E;
      default:   return ST_L;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("digits",   {seg3, seg2, seg1, seg0}, exp_segs());
    check("status",   segStatus, exp_status());
    check("unlocked", unlocked, (mode == M_OPEN || mode == M_PROGRAM));
    check("alarm",    alarm, (mode == M_LOCKOUT));
  endtask

  // Drive one cycle of input, let the edge happen, then compare.
  task automatic do_cycle(input logic v, input logic [3:0] k);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    #1;
    model_step(v, k);
    check_outputs();
    key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    do_cycle(1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 4'h0);
  endtask

  // Four digits then enter, then let CHECK resolve.
  task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'hB);
    idle(1);
  endtask

  task automatic apply_reset();
    key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  int alarm_cnt;

  initial begin
    #2;
    // Reset
    apply_reset();

    // Unlock and relock
    press(4'd1);
    check("seg0_after_1", seg0, 7'b1111001);
    press(4'd2); press(4'd3); press(4'd4);
    check("seg3_after_1234", seg3, 7'b1111001);
    check("seg0_after_1234", seg0, 7'b0011001);
    press(4'hB);
    idle(1);
    check("unlock_1234", unlocked, 1'b1);
    press(4'hB);
    check("relock", unlocked, 1'b0);

    // Lockout
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hB);
    alarm_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      press(4'($urandom_range(0, 12)));
      if (alarm) alarm_cnt++;
    end
    check("lockout_len", alarm_cnt, LC);
    press(4'hA);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    check("unlock_after_lockout", unlocked, 1'b1);
    press(4'hB);

    // Buffer edge cases
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
    check("fifth_digit_ignored", {seg3, seg2, seg1, seg0},
          {glyph_tab[9], glyph_tab[8], glyph_tab[7], glyph_tab[6]});
    press(4'hA);
    check("clear_blank", {seg3, seg2, seg1, seg0}, {4{BLANK}});
    press(4'd1); press(4'd2); press(4'hB);
    idle(1);
    press(4'hE);
    press(4'hC);
    press(4'hA);

    // Reprogram
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    press(4'hC);
    press(4'd0); press(4'd0); press(4'd7); press(4'd7); press(4'hB);
    check("program_back_to_u", segStatus, ST_U);
    press(4'hB);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    check("old_code_rejected", unlocked, 1'b0);
    enter_code(4'd0, 4'd0, 4'd7, 4'd7);
    check("new_code_accepted", unlocked, 1'b1);
    press(4'hC); press(4'd5); press(4'hA); press(4'hC);
    press(4'hB);
    enter_code(4'd0, 4'd0, 4'd7, 4'd7);
    check("abort_keeps_code", unlocked, 1'b1);
    press(4'hB);

    // Reset during lockout
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    idle(4);
    check("in_lockout", alarm, 1'b1);
    apply_reset();
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    check("fail_cleared_by_reset", alarm, 1'b0);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    check("code_reverted", unlocked, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        for (int j = 0; j < 4; j++) press(4'(code_m[j]));
        press(4'hB);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the digital lock. It accepts decoded keypad events, holds a 4-digit entry buffer, and compares it against a stored code. It also handles failed-attempt lockout and code reprogramming, and drives the four digit glyphs plus one status glyph consumed by the 7-segment scanner. All glyph outputs are registered, active-low, ordered {g,f,e,d,c,b,a}, with 7'b1111111 = blank.

## Interface
- LOCKOUT_CYCLES, 500_000_000: cycles spent in LOCKOUT (≥2, fits 32 bits)
- MAX_TRIES, 3: consecutive failed checks that trigger LOCKOUT (1..7)
- RESET_CODE, 16'h0000: code after reset, four BCD nibbles, [15:12] = first digit entered
- clk  in  1  single system clock, all logic on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0-9 digit, 4'hA clear, 4'hB enter, 4'hC program; 4'hD-4'hF ignored
- seg0  out  7  rightmost digit glyph (most recent digit)
- seg1, seg2, seg3  out  7 each  successively older digits
- segStatus  out  7  status glyph
- unlocked  out  1  high in UNLOCKED and PROGRAM
- alarm  out  1  high in LOCKOUT

## Operation
- States: LOCKED, CHECK, UNLOCKED, PROGRAM, LOCKOUT.
- Entry buffer: 4 BCD nibbles plus count (0..4).
  - A digit key shifts the buffer left and inserts into position 0, count+1.
  - A digit key at count==4 is ignored.
  - Clear (A) sets count=0.
- LOCKED:
  - Enter (B) with count==4 moves to CHECK.
  - Enter with count<4 is ignored.
  - C is ignored.
- CHECK (1 cycle), registered compare of buffer to code:
  - Match: go to UNLOCKED, fail=0.
  - Mismatch: fail+1. If the new fail==MAX_TRIES, go to LOCKOUT; otherwise go to LOCKED.
  - The buffer is cleared on exit either way.
  - key_valid is ignored in CHECK.
- UNLOCKED:
  - C clears the buffer and moves to PROGRAM.
  - B moves to LOCKED (relock) with the buffer cleared.
  - Digits and A are ignored.
- PROGRAM:
  - Digits and A edit the buffer as in LOCKED.
  - B with count==4 writes the buffer to code, clears the buffer, and moves to UNLOCKED.
  - B with count<4 is ignored.
  - C aborts to UNLOCKED with the buffer cleared and the code unchanged.
- LOCKOUT:
  - On entry, the counter loads LOCKOUT_CYCLES-1 and decrements each cycle; all keys are ignored.
  - At 0 the block moves to LOCKED with fail=0.
- Digit glyphs: position i shows buffer[i] if i<count, otherwise blank.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - All digit glyphs are blank in CHECK and LOCKOUT.
- segStatus:
  - L=1000111 in LOCKED and CHECK.
  - U=1000001 in UNLOCKED.
  - P=0001100 in PROGRAM.
  - E=0000110 in LOCKOUT.

## Timing
- Reset (async assert, sync release) sets:
  - state LOCKED, count 0, fail 0, code=RESET_CODE
  - seg0-seg3=1111111, segStatus=1000111, unlocked=0, alarm=0
- Reset mid-LOCKOUT or mid-PROGRAM abandons the operation immediately. The code reverts to RESET_CODE.
- A key strobe in cycle N updates the buffer and glyphs at edge N+1.
- Enter in cycle N gives state CHECK at N+1; the resulting state and outputs are visible at N+2.
- Lockout timing:
  - alarm rises at N+2 and stays high exactly LOCKOUT_CYCLES cycles.
  - LOCKED is visible the following cycle.
- key_valid held high for multiple cycles counts as one key per cycle; upstream guarantees single-cycle strobes.
- fail persists across LOCKED↔CHECK. It clears only on a match, at lockout expiry, or on reset.

## Test plan
Bench settings: LOCKOUT_CYCLES=16, MAX_TRIES=3, RESET_CODE=16'h1234.

- **Reset:** assert rst_n=0 → all digit glyphs 1111111, segStatus 1000111, unlocked=0, alarm=0.
- **Unlock and relock:** keys 1,2,3,4,B → seg3..seg0 = 1111001/0100100/0110000/0011001 after each key. Two cycles after B: segStatus 1000001, unlocked=1, glyphs blank. Then B → LOCKED, unlocked=0.
- **Lockout:** three entries of 1,2,3,5,B → alarm=1 for exactly 16 cycles, segStatus 0000110, keys ignored. Then segStatus 1000111, and 1,2,3,4,B unlocks.
- **Buffer edge cases:**
  - Keys 9,8,7,6,5 → fifth digit ignored, buffer 9876.
  - A → all blank.
  - 1,2,B → no state change.
  - Key_code 4'hE → ignored.
- **Reprogram:**
  - From UNLOCKED: C, 0,0,7,7, B → U.
  - Relock, then 1,2,3,4,B → fail=1.
  - 0,0,7,7,B → unlocked.
  - C,5,A,C abort path leaves code 0077.
- **Reset during lockout:** reset after 5 lockout cycles → alarm=0 immediately, code 1234, fail 0.
